vga_scan_ctrl: RTL and testbench
================================

# vga_scan_ctrl

Raster sequencer for the 640x480 VGA path. Divides the 50 MHz system clock into a 25 MHz pixel enable, generates `hcount`/`vcount` and the playfield window `bounds_draw` that drive the combinational `map` tile decoder, and merges `map`'s `tile_draw` with the sprite hit lines by fixed priority. Produces registered RGB, sync and blank outputs, aligned to each other, for the DAC.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48, horizontal porch and sync widths in pixels (line total 800)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33, vertical porch and sync widths in lines (frame total 525)
- `FIELD_X0`, 128 / `FIELD_X1`, 511, playfield column window, inclusive
- `FIELD_Y0`, 0 / `FIELD_Y1`, 479, playfield row window, inclusive
- `clk`  in  1  system clock, 50 MHz
- `reset`  in  1  synchronous, active-high
- `tile_draw`  in  1  from `map`; combinational function of current `hcount`/`vcount`/`bounds_draw`
- `player_draw`  in  1  player sprite hit for the current pixel
- `barrel_draw`  in  1  barrel sprite hit for the current pixel
- `hcount`  out  10  current column, 0..799
- `vcount`  out  10  current row, 0..524
- `bounds_draw`  out  1  decoded from `hcount`/`vcount`: 1 when inside the FIELD window and inside the active area
- `pix_en`  out  1  pixel strobe, high every second `clk`
- `hsync`, `vsync`  out  1 each  active-low, registered
- `blank_n`  out  1  registered; 1 = visible pixel
- `rgb`  out  8  registered, RRRGGGBB
- `frame_tick`  out  1  one-`clk` pulse at frame wrap

## Operation
- Phase flop toggles every `clk`; `pix_en` = phase. First `pix_en` high occurs on the 2nd `clk` after `reset` deasserts.
- On `pix_en`:
  - `hcount` increments.
  - At 799, `hcount` wraps to 0 and `vcount` increments.
  - At `vcount` = 524 with `hcount` = 799, both wrap to 0 and `frame_tick` = 1 for that one `clk`.
- Counters hold when `pix_en` = 0.
- `bounds_draw`: combinational decode of the registered counters, so it is stable for the full 2-clk pixel. It gates `map` externally, so `tile_draw` is valid the same pixel.
- Output register, loaded on `pix_en` from the current counters and layer inputs:
  - `hsync` = 0 iff `hcount` in 656..751.
  - `vsync` = 0 iff `vcount` in 490..491.
  - `blank_n` = (`hcount` < 640 && `vcount` < 480).
  - `rgb` = 0 when not visible. Otherwise priority is `player_draw` > `barrel_draw` > (`tile_draw` && `bounds_draw`) > background, giving COLOR_PLAYER, COLOR_BARREL, COLOR_TILE, COLOR_BG respectively.
- Layer inputs are sampled only on `pix_en` cycles; changes between strobes are ignored.

## Timing
- Reset values:
  - counters 0, phase 0, `pix_en` 0
  - `hsync` 1, `vsync` 1, `blank_n` 0, `rgb` 0, `frame_tick` 0
  - `bounds_draw` = decode(0,0) = 0 with default FIELD_X0
- Latency: `rgb`/`hsync`/`vsync`/`blank_n` reflect the counter value of the previous pixel strobe (1 pixel = 2 `clk`). All four are mutually aligned.
- `reset` asserted mid-frame: all state returns to reset values on the next `clk` edge and is held while `reset` = 1. No partial line is completed.
- `reset` takes priority over `pix_en` in the same cycle.
- Simultaneous hits: priority resolves as above. `tile_draw` outside `bounds_draw` never colors.

## Structure
- Shared package `vga_pkg`: the horizontal/vertical timing constants, `H_TOTAL` = 800 and `V_TOTAL` = 525, sync start/end derived constants, and the color constants.
- Color constants: COLOR_BG 8'h00, COLOR_TILE 8'hE0, COLOR_BARREL 8'hA8, COLOR_PLAYER 8'hFC.
- Sub-module `vga_timing_counter`: phase flop plus h/v counters, `pix_en` and `frame_tick`.
- Top level: window decode, layer priority and output registers.

## Test plan
- Reset → deassert: `pix_en` pattern 0,1,0,1…; `hcount` reaches 1 on the first strobe. `hsync`, `vsync` = 1; `rgb` = 0.
- Run to `hcount` = 799, `vcount` = 10 → next strobe gives `hcount` 0, `vcount` 11. `hsync` low for exactly 96 strobes starting 1 pixel after `hcount` = 656.
- Run to (799,524) → `frame_tick` high for exactly 1 `clk`; counters (0,0); `vsync` low during rows 490–491 only.
- At (150,450), `tile_draw` = 1, sprites 0 → next pixel `rgb` = 8'hE0. At (150,452), `tile_draw` = 0 → 8'h00. At (150,450) with `player_draw` = `barrel_draw` = `tile_draw` = 1 → 8'hFC.
- At (100,450), `tile_draw` forced 1 → `bounds_draw` = 0 and `rgb` = 8'h00. At (700,100), `player_draw` = 1 → `blank_n` = 0 and `rgb` = 0.
- Assert `reset` at (300,200) for 1 `clk` → next edge: counters 0, outputs at reset values. Resumes cleanly.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing, window and color constants for the 640x480 VGA scan path.
package vga_pkg;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned RGB_W = 8;

  // Horizontal timing in pixels
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // Vertical timing in lines
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync pulse windows, inclusive
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Playfield window, inclusive
  localparam int unsigned FIELD_X0 = 128;
  localparam int unsigned FIELD_X1 = 511;
  localparam int unsigned FIELD_Y0 = 0;
  localparam int unsigned FIELD_Y1 = 479;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RGB_W-1:0] rgb_t;

  // RRRGGGBB palette
  localparam rgb_t COLOR_BG     = 8'h00;
  localparam rgb_t COLOR_TILE   = 8'hE0;
  localparam rgb_t COLOR_BARREL = 8'hA8;
  localparam rgb_t COLOR_PLAYER = 8'hFC;

  // Registered DAC-side payload
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
    rgb_t rgb;
  } vga_out_t;

  // Inclusive range test; the wrapped subtraction keeps a zero lower bound free of constant compares
  function automatic logic in_range(input cnt_t x, input cnt_t lo, input cnt_t hi);
    return cnt_t'(x - lo) <= cnt_t'(hi - lo);
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-phase divider and raster h/v counters with frame wrap pulse.
module vga_timing_counter
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             frame_tick
);

  logic phase_q, phase_d;
  cnt_t hcount_q, hcount_d;
  cnt_t vcount_q, vcount_d;
  logic frame_tick_q, frame_tick_d;
  logic h_last_c, v_last_c;

  // Next-state: advance the raster one pixel on each strobe, wrapping line and frame
  always_comb begin
    h_last_c     = (hcount_q == CNT_W'(H_TOTAL - 1));
    v_last_c     = (vcount_q == CNT_W'(V_TOTAL - 1));
    phase_d      = ~phase_q;
    hcount_d     = hcount_q;
    vcount_d     = vcount_q;
    frame_tick_d = 1'b0;
    if (phase_q) begin
      if (h_last_c) begin
        hcount_d = '0;
        if (v_last_c) begin
          vcount_d     = '0;
          frame_tick_d = 1'b1;
        end else begin
          vcount_d = vcount_q + CNT_W'(1);
        end
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
    end
  end

  // State register; counters are rewritten every clk so holds are explicit in the _d path
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= 1'b0;
      hcount_q     <= '0;
      vcount_q     <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pix_en     = phase_q;
  assign hcount     = hcount_q;
  assign vcount     = vcount_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster sequencer: playfield window decode, layer priority and aligned DAC output register.
module vga_scan_ctrl
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tile_draw,
  input  logic             player_draw,
  input  logic             barrel_draw,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             bounds_draw,
  output logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             blank_n,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_tick
);

  logic     visible_c;
  vga_out_t out_q, out_d;

  vga_timing_counter u_tc (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .hcount     (hcount),
    .vcount     (vcount),
    .frame_tick (frame_tick)
  );

  // Window decode straight off the counter registers, stable for the whole 2-clk pixel
  always_comb begin
    visible_c   = (hcount < CNT_W'(H_ACTIVE)) && (vcount < CNT_W'(V_ACTIVE));
    bounds_draw = visible_c
                  && in_range(hcount, CNT_W'(FIELD_X0), CNT_W'(FIELD_X1))
                  && in_range(vcount, CNT_W'(FIELD_Y0), CNT_W'(FIELD_Y1));
  end

  // Output next-state: syncs, blank and layer priority captured only on the pixel strobe
  always_comb begin
    out_d = out_q;
    if (pix_en) begin
      out_d.hsync   = ~in_range(hcount, CNT_W'(H_SYNC_START), CNT_W'(H_SYNC_END));
      out_d.vsync   = ~in_range(vcount, CNT_W'(V_SYNC_START), CNT_W'(V_SYNC_END));
      out_d.blank_n = visible_c;
      if (!visible_c) begin
        out_d.rgb = '0;
      end else if (player_draw) begin
        out_d.rgb = COLOR_PLAYER;
      end else if (barrel_draw) begin
        out_d.rgb = COLOR_BARREL;
      end else if (tile_draw && bounds_draw) begin
        out_d.rgb = COLOR_TILE;
      end else begin
        out_d.rgb = COLOR_BG;
      end
    end
  end

  // Output register; reset wins over a coincident strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0, rgb: '0};
    end else begin
      out_q <= out_d;
    end
  end

  assign hsync   = out_q.hsync;
  assign vsync   = out_q.vsync;
  assign blank_n = out_q.blank_n;
  assign rgb     = out_q.rgb;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl: expected pixels are queued at each strobe and checked one pixel later.
module tb_vga_scan_ctrl;

  localparam int LINE  = 800;
  localparam int FRAME = 800 * 525;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tile_draw = 1'b0;
  logic       player_draw = 1'b0;
  logic       barrel_draw = 1'b0;
  logic [9:0] hcount, vcount;
  logic       bounds_draw, pix_en, hsync, vsync, blank_n, frame_tick;
  logic [7:0] rgb;

  vga_scan_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .tile_draw   (tile_draw),
    .player_draw (player_draw),
    .barrel_draw (barrel_draw),
    .hcount      (hcount),
    .vcount      (vcount),
    .bounds_draw (bounds_draw),
    .pix_en      (pix_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .rgb         (rgb),
    .frame_tick  (frame_tick)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bn;
    logic [7:0] rgb;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         pos = 0;          // raster position expected at the next negedge
  logic       exp_pix = 1'b0;   // pix_en expected at the next negedge
  logic       exp_ft = 1'b0;    // frame_tick expected at the next negedge
  int         hs_low = 0;
  int         vs_low = 0;
  int         ft_cnt = 0;
  logic [9:0] jump_h = '0;
  logic [9:0] jump_v = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (model h=%0d v=%0d)", tag, act, exp, pos % LINE, pos / LINE);
    end
  endtask

  // Reference pixel: what the DUT must present one strobe after seeing (h,v) and these layers
  function automatic exp_t model_px(input int h, input int v, input logic t, input logic p, input logic b);
    exp_t e;
    logic vis, win;
    vis   = (h < 640) && (v < 480);
    win   = vis && (h >= 128) && (h <= 511);
    e.hs  = !((h >= 656) && (h <= 751));
    e.vs  = !((v == 490) || (v == 491));
    e.bn  = vis;
    if (!vis)         e.rgb = 8'h00;
    else if (p)       e.rgb = 8'hFC;
    else if (b)       e.rgb = 8'hA8;
    else if (t && win) e.rgb = 8'hE0;
    else              e.rgb = 8'h00;
    return e;
  endfunction

  // One clk: check counters/strobe, retire a pixel after a strobe, drive layers, advance model
  task automatic cycle(input logic t, input logic p, input logic b);
    int   h, v;
    exp_t e;
    @(negedge clk);
    h = pos % LINE;
    v = pos / LINE;
    check("pix_en", 32'(pix_en), 32'(exp_pix));
    check("hcount", 32'(hcount), 32'(h));
    check("vcount", 32'(vcount), 32'(v));
    check("bounds_draw", 32'(bounds_draw), 32'((h >= 128) && (h <= 511) && (v < 480)));
    check("frame_tick", 32'(frame_tick), 32'(exp_ft));
    if (frame_tick) ft_cnt++;
    if (!exp_pix && sb.size() > 0) begin
      e = sb.pop_front();
      check("hsync", 32'(hsync), 32'(e.hs));
      check("vsync", 32'(vsync), 32'(e.vs));
      check("blank_n", 32'(blank_n), 32'(e.bn));
      check("rgb", 32'(rgb), 32'(e.rgb));
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
    end
    if (exp_pix) begin
      tile_draw   = t;
      player_draw = p;
      barrel_draw = b;
      sb.push_back(model_px(h, v, t, p, b));
    end else begin
      // Off-strobe noise that must never reach the output
      tile_draw   = 1'($urandom);
      player_draw = 1'($urandom);
      barrel_draw = 1'($urandom);
    end
    exp_ft = exp_pix && (pos == FRAME - 1);
    if (exp_pix) pos = (pos + 1) % FRAME;
    exp_pix = !exp_pix;
  endtask

  task automatic cycle_rand();
    cycle(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
  endtask

  task automatic run_n(input int k);
    repeat (k) cycle_rand();
  endtask

  // Hold reset for k clks, checking reset values each clk, then release
  task automatic do_reset(input int k);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    repeat (k) begin
      @(negedge clk);
      check("rst_pix_en", 32'(pix_en), 32'(0));
      check("rst_hcount", 32'(hcount), 32'(0));
      check("rst_vcount", 32'(vcount), 32'(0));
      check("rst_bounds", 32'(bounds_draw), 32'(0));
      check("rst_hsync", 32'(hsync), 32'(1));
      check("rst_vsync", 32'(vsync), 32'(1));
      check("rst_blank_n", 32'(blank_n), 32'(0));
      check("rst_rgb", 32'(rgb), 32'(0));
      check("rst_frame_tick", 32'(frame_tick), 32'(0));
    end
    reset   = 1'b0;
    pos     = 0;
    exp_pix = 1'b1;
    exp_ft  = 1'b0;
  endtask

  // Skip ahead in the raster: overwrite the counters across a non-strobe edge
  task automatic jump_to(input int h, input int v);
    if (exp_pix) cycle_rand();
    cycle_rand();
    jump_h = 10'(h);
    jump_v = 10'(v);
    force dut.u_tc.hcount_q = jump_h;
    force dut.u_tc.vcount_q = jump_v;
    @(posedge clk);
    #1;
    release dut.u_tc.hcount_q;
    release dut.u_tc.vcount_q;
    pos = v * LINE + h;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    run_n(20);

    // Line wrap at row 10 and hsync pulse width
    jump_to(640, 10);
    hs_low = 0;
    run_n(400);
    check("hsync_low_strobes", 32'(hs_low), 32'(96));

    // vsync only on rows 490-491
    jump_to(0, 488);
    vs_low = 0;
    run_n(5 * 2 * LINE);
    check("vsync_low_strobes", 32'(vs_low), 32'(2 * LINE));

    // Frame wrap and single frame_tick
    jump_to(780, 524);
    ft_cnt = 0;
    run_n(100);
    check("frame_tick_count", 32'(ft_cnt), 32'(1));

    // Tile inside playfield, then background, then priority stack
    jump_to(150, 450);
    cycle(1'b1, 1'b0, 1'b0); cycle_rand();
    check("tile_px_rgb", 32'(rgb), 32'(8'hE0));
    cycle(1'b1, 1'b0, 1'b1); cycle_rand();
    check("barrel_over_tile", 32'(rgb), 32'(8'hA8));
    jump_to(150, 452);
    cycle(1'b0, 1'b0, 1'b0); cycle_rand();
    check("bg_px_rgb", 32'(rgb), 32'(8'h00));
    jump_to(150, 450);
    cycle(1'b1, 1'b1, 1'b1); cycle_rand();
    check("player_top_rgb", 32'(rgb), 32'(8'hFC));

    // Tile outside the window never colors; window edges 127/128 and 511/512
    jump_to(100, 450);
    cycle(1'b1, 1'b0, 1'b0); cycle_rand();
    check("tile_outside_rgb", 32'(rgb), 32'(8'h00));
    jump_to(126, 300);
    repeat (4) begin cycle(1'b1, 1'b0, 1'b0); cycle_rand(); end
    jump_to(510, 479);
    repeat (4) begin cycle(1'b1, 1'b0, 1'b0); cycle_rand(); end

    // Player hit in horizontal blanking stays dark
    jump_to(700, 100);
    cycle(1'b0, 1'b1, 1'b0); cycle_rand();
    check("blank_player_bn", 32'(blank_n), 32'(0));
    check("blank_player_rgb", 32'(rgb), 32'(8'h00));

    // Random traffic across the playfield
    jump_to(100, 200);
    run_n(3000);

    // Mid-frame reset coinciding with a strobe, then clean restart
    jump_to(300, 200);
    do_reset(1);
    run_n(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
